// File: rtl/sobel_pkg.sv
// ---------------------------------------------------------------------------
// sobel_pkg
// Shared definitions for the Sobel pipeline: pixel width, default frame
// geometry and the frame-sequencing state encoding that the window generator,
// the gradient stage and the output stage all use.
// ---------------------------------------------------------------------------
package sobel_pkg;

    localparam int PIX_W     = 8;
    localparam int H_DEFAULT = 200;
    localparam int W_DEFAULT = 160;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } stateT;

endpackage

// File: rtl/sobel_window_if.sv
// ---------------------------------------------------------------------------
// sobel_window_if
// Bundles the frame-control handshake, the gray pixel input stream and the
// 3x3 window output of sobel_window.
//   start/ready/frame_done : frame sequencing
//   in_valid/in_gray       : gray pixel stream from the grayscale stage
//   out_valid/w00..w22     : window to the gradient stage (wRC, R row, C col)
// master = the side that feeds pixels and consumes windows
// slave  = the window generator itself
// ---------------------------------------------------------------------------
interface sobel_window_if;
    import sobel_pkg::*;

    logic             start;
    logic             ready;
    logic             in_valid;
    logic [PIX_W-1:0] in_gray;
    logic             out_valid;
    logic             frame_done;
    logic [PIX_W-1:0] w00, w01, w02;
    logic [PIX_W-1:0] w10, w11, w12;
    logic [PIX_W-1:0] w20, w21, w22;

    modport master (
        output start, in_valid, in_gray,
        input  ready, out_valid, frame_done,
        input  w00, w01, w02, w10, w11, w12, w20, w21, w22
    );

    modport slave (
        input  start, in_valid, in_gray,
        output ready, out_valid, frame_done,
        output w00, w01, w02, w10, w11, w12, w20, w21, w22
    );

endinterface

// File: rtl/sobel_line_buffer.sv
// ---------------------------------------------------------------------------
// sobel_line_buffer
// One row of pixel storage, single address, read-before-write: o_rdData shows
// the old contents of i_addr while the write of i_wrData lands at the clock.
//   clk      : system clock
//   i_wrEn   : write strobe
//   i_addr   : column address (shared by read and write)
//   i_wrData : pixel to store
//   o_rdData : pixel previously stored at i_addr
// Contents are never reset; the consumer only uses locations it has written.
// ---------------------------------------------------------------------------
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = W_DEFAULT,
    parameter int WIDTH = PIX_W
) (
    input  logic                     clk,
    input  logic                     i_wrEn,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [WIDTH-1:0]         i_wrData,
    output logic [WIDTH-1:0]         o_rdData
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Asynchronous read so the old value is available in the same cycle as
    // the overwrite.
    assign o_rdData = r_mem[i_addr];

    // Storage write, no reset: stale data is masked by output gating upstream.
    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_addr] <= i_wrData;
        end
    end

endmodule

// File: rtl/sobel_window.sv
// ---------------------------------------------------------------------------
// sobel_window
// Streaming 3x3 neighbourhood generator. Buffers the two previous rows and
// emits every fully interior 3x3 window of an H x W raster frame, one cycle
// after the pixel that completes it.
//   clk : system clock (rising edge)
//   rst : asynchronous active-high reset
//   io  : sobel_window_if.slave (start/ready/frame_done, pixel in, window out)
// ---------------------------------------------------------------------------
module sobel_window
    import sobel_pkg::*;
#(
    parameter int H = H_DEFAULT,
    parameter int W = W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    sobel_window_if.slave  io
);

    localparam int CW = $clog2(W);
    localparam int RW = $clog2(H);
    localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

    stateT                          r_state, w_nextState;
    logic [CW-1:0]                  r_col;
    logic [RW-1:0]                  r_row;
    logic                           w_ready;
    logic                           w_start;
    logic                           w_accept;
    logic                           w_lastPix;
    logic                           w_emit;
    logic [PIX_W-1:0]               w_lineA;
    logic [PIX_W-1:0]               w_lineB;
    logic [2:0][2:0][PIX_W-1:0]     r_win;
    logic [2:0][2:0][PIX_W-1:0]     w_shift;
    logic [2:0][2:0][PIX_W-1:0]     r_out;
    logic                           r_outValid;
    logic                           r_frameDone;

    assign w_start   = (r_state == IDLE) && io.start;
    assign w_accept  = (r_state == RUN) && io.in_valid;
    assign w_lastPix = w_accept && (r_col == COL_LAST) && (r_row == ROW_LAST);
    // Windows at col < 2 straddle the previous row end; rows < 2 are partial.
    assign w_emit    = w_accept && (r_row >= RW'(2)) && (r_col >= CW'(2));

    // State register for frame sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: a start pulse opens a frame, the last pixel closes it,
    // so ready is back in the same cycle as frame_done.
    always_comb begin
        w_nextState = r_state;
        w_ready     = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (io.start) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (w_lastPix) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Raster position of the next pixel; cleared by start, advanced per accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_start) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // lineA holds row-1, lineB holds row-2; each accept pushes the column down.
    sobel_line_buffer #(.DEPTH(W), .WIDTH(PIX_W)) u_lineA (
        .clk      (clk),
        .i_wrEn   (w_accept),
        .i_addr   (r_col),
        .i_wrData (io.in_gray),
        .o_rdData (w_lineA)
    );

    sobel_line_buffer #(.DEPTH(W), .WIDTH(PIX_W)) u_lineB (
        .clk      (clk),
        .i_wrEn   (w_accept),
        .i_addr   (r_col),
        .i_wrData (w_lineA),
        .o_rdData (w_lineB)
    );

    // Window shifted left by one column with the new column on the right.
    always_comb begin
        w_shift       = r_win;
        w_shift[0][0] = r_win[0][1];
        w_shift[0][1] = r_win[0][2];
        w_shift[0][2] = w_lineB;
        w_shift[1][0] = r_win[1][1];
        w_shift[1][1] = r_win[1][2];
        w_shift[1][2] = w_lineA;
        w_shift[2][0] = r_win[2][1];
        w_shift[2][1] = r_win[2][2];
        w_shift[2][2] = io.in_gray;
    end

    // The working window shifts on every accepted pixel, while the output copy
    // only loads on interior windows so the ports hold during suppressed ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win       <= '0;
            r_out       <= '0;
            r_outValid  <= 1'b0;
            r_frameDone <= 1'b0;
        end else begin
            r_outValid  <= w_emit;
            r_frameDone <= w_lastPix;
            if (w_accept) begin
                r_win <= w_shift;
            end
            if (w_emit) begin
                r_out <= w_shift;
            end
        end
    end

    assign io.ready      = w_ready;
    assign io.out_valid  = r_outValid;
    assign io.frame_done = r_frameDone;
    assign io.w00 = r_out[0][0];
    assign io.w01 = r_out[0][1];
    assign io.w02 = r_out[0][2];
    assign io.w10 = r_out[1][0];
    assign io.w11 = r_out[1][1];
    assign io.w12 = r_out[1][2];
    assign io.w20 = r_out[2][0];
    assign io.w21 = r_out[2][1];
    assign io.w22 = r_out[2][2];

endmodule

// File: tb/tb_sobel_window.sv
// ---------------------------------------------------------------------------
// tb_sobel_window
// Directed and randomized bench for sobel_window. A small 4x5 instance covers
// the directed frame scenarios; a default-size instance runs two back-to-back
// random frames. Expected windows are cut straight out of a stored image.
// ---------------------------------------------------------------------------
module tb_sobel_window;
    import sobel_pkg::*;

    localparam int SH = 4;
    localparam int SW = 5;
    localparam int LH = H_DEFAULT;
    localparam int LW = W_DEFAULT;
    localparam int SWIN = (SH - 2) * (SW - 2);
    localparam int LWIN = (LH - 2) * (LW - 2);

    typedef struct packed {
        logic [71:0] win;
        logic        last;
    } winT;

    logic clk = 1'b0;
    logic rstS = 1'b0;
    logic rstL = 1'b0;

    sobel_window_if sIf ();
    sobel_window_if lIf ();

    sobel_window #(.H(SH), .W(SW)) dutS (.clk(clk), .rst(rstS), .io(sIf));
    sobel_window #(.H(LH), .W(LW)) dutL (.clk(clk), .rst(rstL), .io(lIf));

    always #5 clk = ~clk;

    int          checks = 0;
    int          passes = 0;
    winT         sQ[$];
    winT         lQ[$];
    winT         sExp;
    winT         lExp;
    logic [7:0]  sImg [SH][SW];
    logic [7:0]  lImg [LH][LW];
    int          sWinCount = 0;
    int          sDoneCount = 0;
    int          lWinCount = 0;
    int          lDoneCount = 0;
    logic [71:0] sFirstWin = '0;
    logic [71:0] sLastWin = '0;
    logic        sPrevValid = 1'b0;
    logic        lPrevValid = 1'b0;

    // One comparison: counts it and reports a mismatch with both values.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    function automatic logic [71:0] sWin();
        return {sIf.w00, sIf.w01, sIf.w02, sIf.w10, sIf.w11, sIf.w12,
                sIf.w20, sIf.w21, sIf.w22};
    endfunction

    function automatic logic [71:0] lWin();
        return {lIf.w00, lIf.w01, lIf.w02, lIf.w10, lIf.w11, lIf.w12,
                lIf.w20, lIf.w21, lIf.w22};
    endfunction

    // Fill the small image and, if asked, list its interior windows in raster order.
    task automatic buildSmall(input bit randomPix, input bit pushQ);
        winT e;
        for (int r = 0; r < SH; r++)
            for (int c = 0; c < SW; c++)
                sImg[r][c] = randomPix ? 8'($urandom) : 8'(r * 16 + c);
        if (pushQ) begin
            for (int r = 2; r < SH; r++) begin
                for (int c = 2; c < SW; c++) begin
                    e.win = '0;
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            e.win = {e.win[63:0], sImg[r-2+i][c-2+j]};
                    e.last = (r == SH - 1) && (c == SW - 1);
                    sQ.push_back(e);
                end
            end
        end
    endtask

    task automatic buildLarge();
        winT e;
        for (int r = 0; r < LH; r++)
            for (int c = 0; c < LW; c++)
                lImg[r][c] = 8'($urandom);
        for (int r = 2; r < LH; r++) begin
            for (int c = 2; c < LW; c++) begin
                e.win = '0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        e.win = {e.win[63:0], lImg[r-2+i][c-2+j]};
                e.last = (r == LH - 1) && (c == LW - 1);
                lQ.push_back(e);
            end
        end
    endtask

    // Watch the small instance: every window must be the next expected one,
    // must follow an accepted pixel, and frame_done must ride on the last one.
    always @(negedge clk) begin
        if (sIf.out_valid) begin
            checkOutput("s window after gap", 128'(sPrevValid), 128'(1));
            if (sQ.size() == 0) begin
                checkOutput("s unexpected window", 128'(sQ.size()), 128'(1));
            end else begin
                sExp = sQ.pop_front();
                checkOutput("s window", 128'({sWin(), sIf.frame_done}),
                            128'({sExp.win, sExp.last}));
            end
            if (sWinCount == 0) sFirstWin = sWin();
            if (sIf.frame_done) sLastWin = sWin();
            sWinCount++;
        end else if (sIf.frame_done) begin
            checkOutput("s done without window", 128'(sIf.out_valid), 128'(1));
        end
        if (sIf.frame_done) sDoneCount++;
        sPrevValid = sIf.in_valid;
    end

    // Same watch on the full-size instance.
    always @(negedge clk) begin
        if (lIf.out_valid) begin
            checkOutput("l window after gap", 128'(lPrevValid), 128'(1));
            if (lQ.size() == 0) begin
                checkOutput("l unexpected window", 128'(lQ.size()), 128'(1));
            end else begin
                lExp = lQ.pop_front();
                checkOutput("l window", 128'({lWin(), lIf.frame_done}),
                            128'({lExp.win, lExp.last}));
            end
            lWinCount++;
        end else if (lIf.frame_done) begin
            checkOutput("l done without window", 128'(lIf.out_valid), 128'(1));
        end
        if (lIf.frame_done) lDoneCount++;
        lPrevValid = lIf.in_valid;
    end

    // Run one small frame: start, then pixels with optional gaps, an optional
    // stray start at pixel restartAt, or a reset after abortAt pixels.
    task automatic applyStimulus(input bit randomPix, input int gapLen,
                                 input int restartAt, input int abortAt);
        int p;
        sWinCount  = 0;
        sDoneCount = 0;
        buildSmall(randomPix, abortAt < 0);
        @(posedge clk); #1;
        sIf.start = 1'b1;
        @(posedge clk); #1;
        sIf.start = 1'b0;
        checkOutput("s ready in run", 128'(sIf.ready), 128'(0));
        p = 0;
        for (int r = 0; r < SH; r++) begin
            for (int c = 0; c < SW; c++) begin
                if (p == abortAt) begin
                    #2 rstS = 1'b1;
                    #1;
                    checkOutput("s abort ready", 128'(sIf.ready), 128'(1));
                    checkOutput("s abort out_valid", 128'(sIf.out_valid), 128'(0));
                    checkOutput("s abort frame_done", 128'(sIf.frame_done), 128'(0));
                    checkOutput("s abort window", 128'(sWin()), 128'(0));
                    sIf.in_valid = 1'b0;
                    @(posedge clk); #1;
                    rstS = 1'b0;
                    repeat (3) @(posedge clk);
                    #1;
                    checkOutput("s abort no done", 128'(sDoneCount), 128'(0));
                    return;
                end
                sIf.in_valid = 1'b1;
                sIf.in_gray  = sImg[r][c];
                sIf.start    = (p == restartAt);
                @(posedge clk); #1;
                sIf.start = 1'b0;
                if (gapLen > 0) begin
                    sIf.in_valid = 1'b0;
                    sIf.in_gray  = 8'hAA;
                    repeat (gapLen) @(posedge clk);
                    #1;
                end
                p++;
            end
        end
        sIf.in_valid = 1'b0;
        checkOutput("s ready after frame", 128'(sIf.ready), 128'(1));
        repeat (3) @(posedge clk);
        #1;
        checkOutput("s queue drained", 128'(sQ.size()), 128'(0));
        checkOutput("s window count", 128'(sWinCount), 128'(SWIN));
        checkOutput("s done count", 128'(sDoneCount), 128'(1));
    endtask

    initial begin
        sIf.start = 1'b0; sIf.in_valid = 1'b0; sIf.in_gray = 8'h00;
        lIf.start = 1'b0; lIf.in_valid = 1'b0; lIf.in_gray = 8'h00;

        // Reset state.
        #1;
        rstS = 1'b1;
        rstL = 1'b1;
        #2;
        checkOutput("reset ready", 128'(sIf.ready), 128'(1));
        checkOutput("reset out_valid", 128'(sIf.out_valid), 128'(0));
        checkOutput("reset frame_done", 128'(sIf.frame_done), 128'(0));
        checkOutput("reset window", 128'(sWin()), 128'(0));
        checkOutput("reset ready large", 128'(lIf.ready), 128'(1));
        @(posedge clk); #1;
        rstS = 1'b0;
        rstL = 1'b0;

        // Ramp frame, continuous pixels.
        $display("[TB] ramp frame, continuous");
        applyStimulus(1'b0, 0, -1, -1);
        checkOutput("ramp first window", 128'(sFirstWin), 128'(72'h000102_101112_202122));
        checkOutput("ramp last window", 128'(sLastWin), 128'(72'h121314_222324_323334));

        // Ramp frame, in_valid pattern 1,0,0.
        $display("[TB] ramp frame, gapped");
        applyStimulus(1'b0, 2, -1, -1);
        checkOutput("gap first window", 128'(sFirstWin), 128'(72'h000102_101112_202122));
        checkOutput("gap last window", 128'(sLastWin), 128'(72'h121314_222324_323334));

        // Pixels offered while idle must be dropped.
        $display("[TB] idle pixels then frame");
        sWinCount = 0;
        sIf.in_valid = 1'b1;
        sIf.in_gray  = 8'hFF;
        repeat (10) @(posedge clk);
        #1;
        sIf.in_valid = 1'b0;
        checkOutput("idle no window", 128'(sWinCount), 128'(0));
        checkOutput("idle ready", 128'(sIf.ready), 128'(1));
        applyStimulus(1'b0, 0, -1, -1);
        checkOutput("idle first w22", 128'(sFirstWin[7:0]), 128'(8'h22));
        checkOutput("idle first window", 128'(sFirstWin), 128'(72'h000102_101112_202122));

        // Stray start in the middle of a frame.
        $display("[TB] start during run");
        applyStimulus(1'b0, 0, 7, -1);

        // Random content, then a reset after 12 pixels, then a clean frame.
        $display("[TB] random frame, abort, recovery");
        applyStimulus(1'b1, 0, -1, -1);
        applyStimulus(1'b1, 0, -1, 12);
        applyStimulus(1'b0, 0, -1, -1);
        checkOutput("recover first window", 128'(sFirstWin), 128'(72'h000102_101112_202122));
        checkOutput("recover last window", 128'(sLastWin), 128'(72'h121314_222324_323334));

        // Two random full-size frames, second started in the frame_done cycle.
        $display("[TB] full-size random frames");
        lWinCount  = 0;
        lDoneCount = 0;
        buildLarge();
        @(posedge clk); #1;
        lIf.start = 1'b1;
        @(posedge clk); #1;
        lIf.start = 1'b0;
        checkOutput("l ready in run", 128'(lIf.ready), 128'(0));
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < LH; r++) begin
                for (int c = 0; c < LW; c++) begin
                    lIf.in_valid = 1'b1;
                    lIf.in_gray  = lImg[r][c];
                    @(posedge clk); #1;
                end
            end
            lIf.in_valid = 1'b0;
            checkOutput("l done pulse", 128'(lIf.frame_done), 128'(1));
            checkOutput("l ready at done", 128'(lIf.ready), 128'(1));
            if (f == 0) begin
                buildLarge();
                lIf.start = 1'b1;
                @(posedge clk); #1;
                lIf.start = 1'b0;
                checkOutput("l frame0 windows", 128'(lWinCount), 128'(LWIN));
                checkOutput("l restarted", 128'(lIf.ready), 128'(0));
                lWinCount = 0;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("l frame1 windows", 128'(lWinCount), 128'(LWIN));
        checkOutput("l done count", 128'(lDoneCount), 128'(2));
        checkOutput("l queue drained", 128'(lQ.size()), 128'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
